// File: rtl/conv3x3_stream_engine_if.sv
// Pixel/result bus of the 3x3 convolution engine, plus its control and debug view.
// Inputs are sampled on every rising clk edge while ena=1; results are single-cycle out_valid pulses with no backpressure.
interface conv3x3_stream_engine_if #(
    parameter int DATA_W = 8
);
    logic              ena;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              frame_done;
    logic              kernel_ok;
    logic              dbg_run;

    modport master (
        output ena, mode, in_valid, in_data,
        input  out_valid, out_data, frame_done, kernel_ok, dbg_run
    );

    modport slave (
        input  ena, mode, in_valid, in_data,
        output out_valid, out_data, frame_done, kernel_ok, dbg_run
    );
endinterface

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution: two line buffers feed a sliding window, a loadable signed kernel,
// a product register stage and a sum/shift/clamp stage (result two edges after the accepting beat).
module conv3x3_stream_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    conv3x3_stream_engine_if.slave      bus
);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int ACC_W  = DATA_W + COEF_W + 4;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic signed [ACC_W-1:0] MAX_OUT = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic [3:0]                 idx_q, idx_d;
    logic                       kernel_ok_q, kernel_ok_d;
    logic signed [COEF_W-1:0]   coef_q [9];
    logic signed [COEF_W-1:0]   coef_d [9];
    logic [DATA_W-1:0]          lb1_q [IMG_W];
    logic [DATA_W-1:0]          lb1_d [IMG_W];
    logic [DATA_W-1:0]          lb2_q [IMG_W];
    logic [DATA_W-1:0]          lb2_d [IMG_W];
    logic [DATA_W-1:0]          win_q [9];
    logic [DATA_W-1:0]          win_d [9];
    logic                       win_v_q, win_v_d;
    logic signed [PROD_W-1:0]   prod_q [9];
    logic signed [PROD_W-1:0]   prod_d [9];
    logic                       prod_v_q, prod_v_d;
    logic                       out_v_q, out_v_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;
    logic                       frame_done_q, frame_done_d;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    res;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        idx_d        = idx_q;
        kernel_ok_d  = kernel_ok_q;
        coef_d       = coef_q;
        lb1_d        = lb1_q;
        lb2_d        = lb2_q;
        win_d        = win_q;
        win_v_d      = win_v_q;
        prod_d       = prod_q;
        prod_v_d     = prod_v_q;
        out_v_d      = out_v_q;
        out_data_d   = out_data_q;
        frame_done_d = frame_done_q;
        acc          = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + {{(ACC_W - PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
        res = acc >>> SHIFT;

        // With ena low nothing moves: the defaults above freeze every register.
        if (bus.ena) begin
            state_d      = bus.mode ? ST_RUN : ST_LOAD;
            frame_done_d = 1'b0;
            win_v_d      = 1'b0;
            prod_v_d     = win_v_q;
            out_v_d      = prod_v_q;
            for (int i = 0; i < 9; i++) begin
                prod_d[i] = {{(PROD_W - COEF_W){coef_q[i][COEF_W-1]}}, coef_q[i]}
                          * {{(PROD_W - DATA_W){1'b0}}, win_q[i]};
            end
            if (prod_v_q) begin
                if (res < 0)
                    out_data_d = '0;
                else if (res > MAX_OUT)
                    out_data_d = MAX_OUT[DATA_W-1:0];
                else
                    out_data_d = res[DATA_W-1:0];
            end

            if (state_d != state_q) begin
                col_d    = '0;
                row_d    = '0;
                idx_d    = '0;
                prod_v_d = 1'b0;
                out_v_d  = 1'b0;
            end else if (bus.in_valid && state_q == ST_LOAD) begin
                coef_d[idx_q] = bus.in_data[COEF_W-1:0];
                if (idx_q == 4'd8) begin
                    idx_d       = '0;
                    kernel_ok_d = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end else if (bus.in_valid) begin
                // Window row 0 is the oldest line; column 2 is the newest pixel.
                win_d[0] = win_q[1];
                win_d[1] = win_q[2];
                win_d[2] = lb2_q[col_q];
                win_d[3] = win_q[4];
                win_d[4] = win_q[5];
                win_d[5] = lb1_q[col_q];
                win_d[6] = win_q[7];
                win_d[7] = win_q[8];
                win_d[8] = bus.in_data;
                lb2_d[col_q] = lb1_q[col_q];
                lb1_d[col_q] = bus.in_data;
                win_v_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            col_q        <= '0;
            row_q        <= '0;
            idx_q        <= '0;
            kernel_ok_q  <= 1'b0;
            win_v_q      <= 1'b0;
            prod_v_q     <= 1'b0;
            out_v_q      <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                coef_q[i] <= '0;
                win_q[i]  <= '0;
                prod_q[i] <= '0;
            end
            for (int i = 0; i < IMG_W; i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            kernel_ok_q  <= kernel_ok_d;
            win_v_q      <= win_v_d;
            prod_v_q     <= prod_v_d;
            out_v_q      <= out_v_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            coef_q       <= coef_d;
            win_q        <= win_d;
            prod_q       <= prod_d;
            lb1_q        <= lb1_d;
            lb2_q        <= lb2_d;
        end
    end

    assign bus.out_valid  = out_v_q & bus.ena;
    assign bus.frame_done = frame_done_q & bus.ena;
    assign bus.out_data   = out_data_q;
    assign bus.kernel_ok  = kernel_ok_q;
    assign bus.dbg_run    = (state_q == ST_RUN);
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed-plus-random bench for conv3x3_stream_engine; expected results come from a plain
// 2-D convolution of the frame as streamed, queued with the cycle each result is due.
module tb_conv3x3_stream_engine;
    localparam int DATA_W = 8;
    localparam int COEF_W = 4;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int SHIFT  = 0;
    localparam int NRES   = (IMG_W - 2) * (IMG_H - 2);

    logic clk;
    logic rst_n;

    conv3x3_stream_engine_if #(.DATA_W(DATA_W)) bus();

    conv3x3_stream_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state and scoreboard
    int              total;
    int              bad;
    int              cyc;
    int              m_kern [9];
    int              m_kidx;
    bit              m_kok;
    bit              m_mode;
    int              m_pix;
    int              m_img [IMG_H][IMG_W];
    logic [DATA_W-1:0] exp_q[$];
    int              exp_cyc_q[$];
    bit              loose;
    int              n_out;
    int              first_out;
    int              kbuf [13];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] conv_ref(input int r, input int c);
        int sum;
        int res;
        sum = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sum += m_kern[i*3+j] * m_img[r-2+i][c-2+j];
        res = sum >>> SHIFT;
        if (res < 0) res = 0;
        if (res > (1 << DATA_W) - 1) res = (1 << DATA_W) - 1;
        return DATA_W'(res);
    endfunction

    function automatic logic [DATA_W-1:0] pix_val(input int kind, input int r, input int c);
        case (kind)
            0:       return DATA_W'(r * IMG_W + c);
            1:       return 8'd255;
            2:       return 8'd100;
            3:       return (r == 3 && c == 4) ? 8'd255 : 8'd0;
            default: return DATA_W'($urandom_range(0, 255));
        endcase
    endfunction

    // One clock: drive inputs, update the model at the edge, check outputs on the falling edge.
    task automatic tick(input logic r_n, input logic e, input logic m, input logic v,
                        input logic [DATA_W-1:0] d);
        bit fd_exp;
        int r;
        int c;
        rst_n = r_n;
        bus.ena = e;
        bus.mode = m;
        bus.in_valid = v;
        bus.in_data = d;
        @(posedge clk);
        cyc++;
        fd_exp = 1'b0;
        if (!r_n) begin
            for (int i = 0; i < 9; i++) m_kern[i] = 0;
            m_kidx = 0;
            m_kok = 1'b0;
            m_mode = 1'b0;
            m_pix = 0;
            exp_q.delete();
            exp_cyc_q.delete();
        end else if (e) begin
            if (m != m_mode) begin
                m_mode = m;
                m_pix = 0;
                m_kidx = 0;
                exp_q.delete();
                exp_cyc_q.delete();
            end else if (v && !m_mode) begin
                m_kern[m_kidx] = int'($signed(d[COEF_W-1:0]));
                if (m_kidx == 8) begin
                    m_kidx = 0;
                    m_kok = 1'b1;
                end else begin
                    m_kidx++;
                end
            end else if (v) begin
                r = m_pix / IMG_W;
                c = m_pix % IMG_W;
                m_img[r][c] = int'(d);
                if (r >= 2 && c >= 2) begin
                    exp_q.push_back(conv_ref(r, c));
                    exp_cyc_q.push_back(loose ? -1 : cyc + 2);
                end
                m_pix++;
                if (m_pix == IMG_W * IMG_H) begin
                    m_pix = 0;
                    fd_exp = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("kernel_ok", 32'(bus.kernel_ok), 32'(m_kok));
        if (!r_n) begin
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_out_data", 32'(bus.out_data), 32'd0);
            check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        end else if (!e) begin
            check("ena0_out_valid", 32'(bus.out_valid), 32'd0);
            check("ena0_frame_done", 32'(bus.frame_done), 32'd0);
        end else begin
            check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
        end
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                logic [DATA_W-1:0] ev;
                int ec;
                ev = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (n_out == 0) first_out = int'(bus.out_data);
                n_out++;
                check("out_data", 32'(bus.out_data), 32'(ev));
                if (ec >= 0) check("latency_cycle", 32'(cyc), 32'(ec));
            end
        end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] >= 0 && exp_cyc_q[0] <= cyc) begin
            check("missing_out", 32'(bus.out_valid), 32'd1);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
    endtask

    // Loads the first n entries of kbuf in LOAD mode, then switches to RUN.
    task automatic load_beats(input int n);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 8'(kbuf[i] & 15));
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic set_kernel(input int k0, input int k1, input int k2, input int k3,
                              input int k4, input int k5, input int k6, input int k7, input int k8);
        kbuf[0] = k0; kbuf[1] = k1; kbuf[2] = k2; kbuf[3] = k3; kbuf[4] = k4;
        kbuf[5] = k5; kbuf[6] = k6; kbuf[7] = k7; kbuf[8] = k8;
        load_beats(9);
    endtask

    task automatic stream_frame(input int kind, input bit gaps, input int pause_at, input int stop_at);
        for (int p = 0; p < IMG_W * IMG_H && p < stop_at; p++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            if (p == pause_at) repeat (5) tick(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
            tick(1'b1, 1'b1, 1'b1, 1'b1, pix_val(kind, p / IMG_W, p % IMG_W));
        end
    endtask

    task automatic drain_and_count(input string tag);
        repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        check(tag, 32'(n_out), 32'(NRES));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // directed steps
    initial begin
        total = 0; bad = 0; cyc = 0; loose = 1'b0; n_out = 0; first_out = -1;
        m_kidx = 0; m_kok = 1'b0; m_mode = 1'b0; m_pix = 0;
        for (int i = 0; i < 9; i++) m_kern[i] = 0;
        for (int i = 0; i < 13; i++) kbuf[i] = 0;
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) m_img[r][c] = 0;
        rst_n = 1'b0; bus.ena = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;

        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // identity kernel on a ramp
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        n_out = 0;
        stream_frame(0, 1'b0, -1, 1000);
        drain_and_count("identity_count");
        check("identity_first", 32'(first_out), 32'd9);

        // saturation high
        set_kernel(7, 7, 7, 7, 7, 7, 7, 7, 7);
        n_out = 0;
        stream_frame(1, 1'b0, -1, 1000);
        drain_and_count("sat_count");

        // Laplacian-like kernel; the centre is 7 since +8 does not fit a 4-bit signed coefficient
        set_kernel(-1, -1, -1, -1, 7, -1, -1, -1, -1);
        n_out = 0;
        stream_frame(2, 1'b0, -1, 1000);
        drain_and_count("flat_count");
        n_out = 0;
        stream_frame(3, 1'b0, -1, 1000);
        drain_and_count("dot_count");

        // input gaps with exact latency tracking
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        n_out = 0;
        stream_frame(0, 1'b1, -1, 1000);
        drain_and_count("gaps_count");

        // random kernel, then four extra coefficients overwrite k0..k3 only
        for (int i = 0; i < 13; i++) kbuf[i] = int'($urandom_range(0, 15));
        load_beats(13);
        n_out = 0;
        stream_frame(4, 1'b1, -1, 1000);
        drain_and_count("reload_count");

        // reset in the middle of a frame, then reload and restream
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        stream_frame(0, 1'b0, -1, 30);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
        set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        n_out = 0;
        stream_frame(0, 1'b0, -1, 1000);
        drain_and_count("post_reset_count");

        // enable held low mid-stream
        loose = 1'b1;
        n_out = 0;
        first_out = -1;
        stream_frame(0, 1'b0, 20, 1000);
        drain_and_count("ena_count");
        check("ena_first", 32'(first_out), 32'd9);
        loose = 1'b0;

        // random pixels through a random kernel
        for (int i = 0; i < 9; i++) kbuf[i] = int'($urandom_range(0, 15));
        load_beats(9);
        n_out = 0;
        stream_frame(4, 1'b1, -1, 1000);
        drain_and_count("random_count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
